// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem
// Brief    : Load/store data memory with a valid/ready request port, fixed
//            wait states, byte/half/word access and error flagging.
// Revision : 1.0
// ============================================================================
module lsu_dmem #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);
  localparam int         AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            err_q, err_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            w_accept, w_req_oor, w_req_mis, w_req_err;
  logic [3:0]      w_req_be;
  logic [31:0]     w_req_wlane;
  logic            w_cur_we, w_cur_err, w_cur_uns;
  logic [1:0]      w_cur_size, w_cur_lane;
  logic [AW-1:0]   w_cur_idx;
  logic [3:0]      w_cur_be;
  logic [31:0]     w_cur_wdata;
  logic            w_enter_resp, w_mem_we;
  logic [31:0]     w_rd_word, w_rd_shift;
  logic [XLEN-1:0] w_load_val;

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign w_accept  = req_valid && req_ready;

  assign w_req_oor = |req_addr[XLEN-1:AW+2];
  assign w_req_mis = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_req_err = w_req_oor || w_req_mis || (req_size == 2'b11);

  always_comb begin
    w_req_be    = 4'b0000;
    w_req_wlane = req_wdata[31:0];
    case (req_size)
      2'b00: begin
        w_req_be    = 4'b0001 << req_addr[1:0];
        w_req_wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_req_wlane = {2{req_wdata[15:0]}};
      end
      2'b10:   w_req_be = 4'b1111;
      default: w_req_be = 4'b0000;
    endcase
  end

  // With zero latency the access completes on the accept edge itself, so the
  // live request stands in for the latched one while idle.
  assign w_cur_we    = req_ready ? req_we          : we_q;
  assign w_cur_err   = req_ready ? w_req_err       : err_q;
  assign w_cur_uns   = req_ready ? req_unsigned    : uns_q;
  assign w_cur_size  = req_ready ? req_size        : size_q;
  assign w_cur_lane  = req_ready ? req_addr[1:0]   : lane_q;
  assign w_cur_idx   = req_ready ? req_addr[AW+1:2] : idx_q;
  assign w_cur_be    = req_ready ? w_req_be        : be_q;
  assign w_cur_wdata = req_ready ? w_req_wlane     : wdata_q;

  assign w_enter_resp = ((state_q == IDLE) && w_accept && (C_LAT == 4'd0)) ||
                        ((state_q == WAIT) && (cnt_q == 4'd1));
  assign w_mem_we     = w_enter_resp && w_cur_we && !w_cur_err && reset;

  assign w_rd_word  = mem[w_cur_idx];
  assign w_rd_shift = w_rd_word >> {w_cur_lane, 3'b000};

  always_comb begin
    case (w_cur_size)
      2'b00:   w_load_val = w_cur_uns ? {{(XLEN-8){1'b0}}, w_rd_shift[7:0]}
                                      : {{(XLEN-8){w_rd_shift[7]}}, w_rd_shift[7:0]};
      2'b01:   w_load_val = w_cur_uns ? {{(XLEN-16){1'b0}}, w_rd_shift[15:0]}
                                      : {{(XLEN-16){w_rd_shift[15]}}, w_rd_shift[15:0]};
      default: w_load_val = w_rd_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    err_d       = err_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          err_d   = w_req_err;
          idx_d   = req_addr[AW+1:2];
          lane_d  = req_addr[1:0];
          be_d    = w_req_be;
          wdata_d = w_req_wlane;
          if (C_LAT == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = C_LAT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (w_enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = w_cur_err;
      rsp_rdata_d = (w_cur_we || w_cur_err) ? '0 : w_load_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      lane_q      <= 2'b00;
      be_q        <= 4'b0000;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_be[b]) mem[w_cur_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: doc/lsu_dmem.md
# lsu_dmem

Parametrised load/store data memory that supersedes the fixed word-only data memory in the single-cycle core. It accepts one request at a time over a valid/ready handshake, with configurable depth and wait-state latency. It supports byte, half and word accesses with sign or zero extension on loads, and flags misaligned or out-of-range accesses. It is the memory-side block for the multi-cycle core, which stalls until the response returns.

## Interface
- `XLEN`, default 32: data and address width. Fixed at 32 for RV32; other values are not supported.
- `DEPTH_WORDS`, default 64: number of 32-bit words. Must be a power of 2, at least 4.
- `LATENCY`, default 2: wait-state cycles inserted before the response. Legal range is 0..15.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: 00 byte, 01 half, 10 word. 11 is illegal and flagged as an error.
- `req_unsigned`, in, 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr`, in, XLEN: byte address.
- `req_wdata`, in, XLEN: store data. Taken from the low bits according to size.
- `rsp_valid`, out, 1: one-cycle response strobe.
- `rsp_rdata`, out, XLEN: load result. 0 for stores and for errors.
- `rsp_err`, out, 1: access was misaligned, out of range, or had an illegal size.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- **States:** IDLE, WAIT, RESP.
- **Reset:** the FSM goes to IDLE. The following outputs reset as listed:
  - `req_ready` = 1
  - `rsp_valid` = 0
  - `rsp_rdata` = 0
  - `rsp_err` = 0
  - `busy` = 0
- **Memory contents are not reset.**
- **Accept:** a request is accepted on a rising edge where `req_valid && req_ready`. All request fields are latched at that edge.
- **Transitions:**
  - IDLE→WAIT on accept. The wait counter loads `LATENCY`.
  - If `LATENCY`=0, IDLE→RESP directly.
  - WAIT decrements the counter on each edge and goes to RESP when the counter is 1 at that edge.
  - RESP→IDLE unconditionally after one cycle.
- **Word index:** `req_addr[$clog2(DEPTH_WORDS)+1:2]`.
- **Out-of-range:** any set address bit above that index field.
- **Misaligned:** half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- **Errors:** any error sets `rsp_err`=1 and `rsp_rdata`=0. No memory write occurs.
- **Byte order:** little-endian. The byte lane is `addr[1:0]` and the half lane is `addr[1]`.
- **Store:** writes only the addressed bytes, with a per-byte enable. The write commits on the edge that enters RESP.
- **Load:** reads the addressed word and extracts the lane. The result is extended to XLEN:
  - `req_unsigned`=1: zero-extended.
  - `req_unsigned`=0: sign-extended from bit 7 (byte) or bit 15 (half).
- **Load data:** `rsp_rdata` and `rsp_err` are registered. They are valid only while `rsp_valid`=1, and are held at 0 otherwise.
- **Requests while busy:** a request presented while `req_ready`=0 is ignored and not queued. The requester must hold it until accepted.
- **Reset mid-operation:** any pending store is discarded and no write occurs. No response is issued.

## Timing
- `req_ready` = (state == IDLE), decoded combinationally from the state register.
- **Request to response:** a request accepted in cycle c gets `rsp_valid`=1 in cycle c+1+`LATENCY` only.
- **Ready timing:** `req_ready` is 0 from cycle c+1 through c+1+`LATENCY`. It returns to 1 in cycle c+2+`LATENCY`.
- **Throughput:** one request per `LATENCY`+2 cycles.
- **Store visibility:** a store's data is visible to any request accepted after the store's RESP cycle.
- **`busy`** equals `!req_ready`.
- **No combinational path** from any `req_*` input to any `rsp_*` output.

## Test plan
1. **Reset values, word round trip:**
   - Stimulus: reset low for 3 cycles; check all outputs at their reset values. With `LATENCY`=2, store word 0xDEADBEEF to 0x10, then load word 0x10.
   - Required: `rsp_valid` exactly 3 cycles after each accept. Load returns 0xDEADBEEF with `rsp_err`=0. `req_ready` low for 3 cycles after each accept.
2. **Byte and half extension:**
   - Stimulus: store word 0x80FF7F01 to 0x20.
   - Required:
     - byte 0x23 signed → 0xFFFFFF80
     - byte 0x23 unsigned → 0x00000080
     - half 0x20 signed → 0x00007F01
     - half 0x22 signed → 0xFFFF80FF
3. **Partial store:**
   - Stimulus: after test 2, store byte 0xAA to 0x21, then load word 0x20.
   - Required: 0x80FFAA01.
4. **Errors:**
   - Stimulus and required response:
     - load word 0x22 → `rsp_err`=1, `rsp_rdata`=0
     - store half 0x21 (data 0x1234) → `rsp_err`=1; word 0x20 unchanged
     - load word 0x100 with `DEPTH_WORDS`=64 → `rsp_err`=1
     - `req_size`=11 → `rsp_err`=1
5. **Zero latency and back-to-back:**
   - Stimulus: `LATENCY`=0, `req_valid` held high with 4 loads.
   - Required: `rsp_valid` in the cycle after each accept. Accepts 2 cycles apart. Exactly 4 responses.
6. **Reset mid-operation:**
   - Stimulus: `LATENCY`=5, store word 0x11111111 to 0x30. Assert reset in the 3rd wait cycle, release it, then load 0x30.
   - Required: no `rsp_valid` for the aborted store. `req_ready`=1 immediately on reset. Load returns the prior contents, not 0x11111111.
